// File: rtl/data_mem_unit_if.sv
// CPU-side data memory port plus the TX byte drain port of data_mem_unit.
// master = CPU / consumer side, slave = the memory unit.
interface data_mem_unit_if #(
    parameter int DATA_LEN = 32
);
    logic [2:0]          mem_fn;
    logic [DATA_LEN-1:0] addr;
    logic [DATA_LEN-1:0] wdata;
    logic [DATA_LEN-1:0] rdata;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic                misalign_err;

    modport master (
        output mem_fn, addr, wdata, tx_ready,
        input  rdata, tx_data, tx_valid, misalign_err
    );
    modport slave (
        input  mem_fn, addr, wdata, tx_ready,
        output rdata, tx_data, tx_valid, misalign_err
    );
endinterface

// File: rtl/data_mem_unit.sv
// Data-side memory unit: byte-lane RAM, TX FIFO, cycle counter, combinational read path.
// Stores, FIFO movement and sticky flags commit on the rising clk edge.
module data_mem_unit #(
    parameter int DATA_LEN    = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] F_LB = 3'd0, F_LH = 3'd1, F_LW = 3'd2, F_LBU = 3'd3,
                           F_LHU = 3'd4, F_SB = 3'd5, F_SH = 3'd6, F_SW = 3'd7;
    localparam logic [DATA_LEN-1:0] A_TX  = DATA_LEN'(32'h8000_0000);
    localparam logic [DATA_LEN-1:0] A_ST  = DATA_LEN'(32'h8000_0004);
    localparam logic [DATA_LEN-1:0] A_CYC = DATA_LEN'(32'h8000_0008);

    logic [3:0][7:0]     r_ram [DEPTH_WORDS];
    logic [7:0]          r_fifo [FIFO_DEPTH];
    logic [FW-1:0]       r_wptr, r_rptr;
    logic [FW:0]         r_count;
    logic                r_ovf, r_misalign;
    logic [DATA_LEN-1:0] r_cycle;

    logic [2:0]          w_fn;
    logic                w_is_load, w_is_store, w_misalign;
    logic                w_in_ram, w_is_tx, w_is_st, w_is_cyc;
    logic [AW-1:0]       w_widx;
    logic [1:0]          w_lane;
    logic [3:0][7:0]     w_word, w_wlanes;
    logic [3:0]          w_be;
    logic [7:0]          w_byte, w_head;
    logic [15:0]         w_half;
    logic                w_ram_we, w_empty, w_full, w_pop, w_push_req, w_push;
    logic [DATA_LEN-1:0] w_rdata;

    assign w_fn       = bus.mem_fn;
    assign w_is_load  = (w_fn <= F_LHU);
    assign w_is_store = !w_is_load;
    assign w_misalign = ((w_fn == F_LH || w_fn == F_LHU || w_fn == F_SH) && bus.addr[0]) ||
                        ((w_fn == F_LW || w_fn == F_SW) && (bus.addr[1:0] != 2'b00));
    assign w_in_ram   = ((bus.addr >> (AW + 2)) == '0);
    assign w_is_tx    = (bus.addr == A_TX);
    assign w_is_st    = (bus.addr == A_ST);
    assign w_is_cyc   = (bus.addr == A_CYC);
    assign w_widx     = bus.addr[AW+1:2];
    assign w_lane     = bus.addr[1:0];
    assign w_word     = r_ram[w_widx];
    assign w_byte     = w_word[w_lane];
    assign w_half     = bus.addr[1] ? {w_word[3], w_word[2]} : {w_word[1], w_word[0]};

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (FW+1)'(FIFO_DEPTH));
    assign w_head     = w_empty ? 8'h00 : r_fifo[r_rptr];
    assign w_pop      = !w_empty && bus.tx_ready;
    assign w_push_req = w_is_store && !w_misalign && w_is_tx;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ram_we   = w_is_store && !w_misalign && w_in_ram;

    always_comb begin
        w_rdata = '0;
        if (w_is_load && !w_misalign) begin
            if (w_in_ram) begin
                case (w_fn)
                    F_LB:    w_rdata = {{(DATA_LEN-8){w_byte[7]}}, w_byte};
                    F_LBU:   w_rdata = DATA_LEN'(w_byte);
                    F_LH:    w_rdata = {{(DATA_LEN-16){w_half[15]}}, w_half};
                    F_LHU:   w_rdata = DATA_LEN'(w_half);
                    default: w_rdata = DATA_LEN'(w_word);
                endcase
            end else if (w_is_tx) begin
                w_rdata = DATA_LEN'(w_head);
            end else if (w_is_st) begin
                w_rdata = DATA_LEN'({r_ovf, w_full, w_empty, 1'b0});
            end else if (w_is_cyc) begin
                w_rdata = r_cycle;
            end
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = bus.wdata[31:0];
        case (w_fn)
            F_SB: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{bus.wdata[7:0]}};
            end
            F_SH: begin
                w_be     = bus.addr[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{bus.wdata[15:0]}};
            end
            F_SW:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Storage arrays are not reset; a write landing while reset is held is discarded.
    always_ff @(posedge clk) begin
        if (reset && w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_ram[w_widx][i] <= w_wlanes[i];
            end
        end
        if (reset && w_push) r_fifo[r_wptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_misalign <= 1'b0;
            r_cycle    <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_push_req && !w_push) r_ovf <= 1'b1;
            if (w_misalign)            r_misalign <= 1'b1;
            if (w_is_cyc && w_fn == F_SW) r_cycle <= bus.wdata;
            else                          r_cycle <= r_cycle + 1'b1;
        end
    end

    assign bus.rdata        = w_rdata;
    assign bus.tx_data      = w_head;
    assign bus.tx_valid     = !w_empty;
    assign bus.misalign_err = r_misalign;
endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: byte-addressed reference model plus literal pins.
module tb_data_mem_unit;
    localparam int DW = 1024;
    localparam int LB = 0, LH = 1, LW = 2, LBU = 3, LHU = 4, SB = 5, SH = 6, SW = 7;
    localparam logic [31:0] TX = 32'h8000_0000, ST = 32'h8000_0004, CY = 32'h8000_0008;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    data_mem_unit_if #(.DATA_LEN(32)) bus ();
    data_mem_unit #(.DATA_LEN(32), .DEPTH_WORDS(DW), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: bytes by address, FIFO as a queue, plain counters/flags.
    byte unsigned m_ram [int];
    logic [7:0]   m_fifo [$];
    logic [31:0]  m_cyc = 0;
    bit           m_ovf = 0;
    bit           m_mis = 0;

    function automatic int fn_size(input int fn);
        if (fn == LB || fn == LBU || fn == SB) return 1;
        if (fn == LH || fn == LHU || fn == SH) return 2;
        return 4;
    endfunction

    function automatic bit m_known(input int fn, input logic [31:0] a);
        int sz = fn_size(fn);
        if (fn > LHU || (a % sz) != 0 || a >= DW * 4) return 1;
        for (int i = 0; i < sz; i++) if (!m_ram.exists(int'(a) + i)) return 0;
        return 1;
    endfunction

    function automatic logic [31:0] m_rdata(input int fn, input logic [31:0] a);
        int sz = fn_size(fn);
        logic [31:0] v = 0;
        if (fn > LHU || (a % sz) != 0) return 0;
        if (a < DW * 4) begin
            for (int i = 0; i < sz; i++) v = v | (32'(m_ram[int'(a) + i]) << (8 * i));
            if (fn == LB && v[7])  v = v | 32'hFFFF_FF00;
            if (fn == LH && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        if (a == TX) return (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 0;
        if (a == ST) return 32'((m_ovf ? 8 : 0) + (m_fifo.size() == 8 ? 4 : 0) + (m_fifo.size() == 0 ? 2 : 0));
        if (a == CY) return m_cyc;
        return 0;
    endfunction

    task automatic model_step(input int fn, input logic [31:0] a, input logic [31:0] wd, input bit r);
        int  sz   = fn_size(fn);
        bit  mis  = (a % sz) != 0;
        bit  pop  = (m_fifo.size() != 0) && r;
        bit  push = 0;
        bit  cld  = 0;
        if (mis) m_mis = 1;
        if (fn >= SB && !mis) begin
            if (a < DW * 4) begin
                for (int i = 0; i < sz; i++) m_ram[int'(a) + i] = wd[8*i +: 8];
            end else if (a == TX) begin
                if (m_fifo.size() == 8 && !pop) m_ovf = 1;
                else push = 1;
            end else if (a == CY && fn == SW) begin
                cld = 1;
            end
        end
        if (pop)  void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(wd[7:0]);
        m_cyc = cld ? wd : m_cyc + 1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One bus cycle: drive, compare all outputs before the edge, then advance the model.
    task automatic cyc(input int fn, input logic [31:0] a, input logic [31:0] wd,
                       input bit chk, input logic [31:0] lit);
        bus.mem_fn   = 3'(fn);
        bus.addr     = a;
        bus.wdata    = wd;
        bus.tx_ready = rdy;
        @(negedge clk);
        if (fn <= LHU && m_known(fn, a)) check("rdata", bus.rdata, m_rdata(fn, a));
        check("tx_valid", 32'(bus.tx_valid), 32'(m_fifo.size() != 0));
        check("tx_data", 32'(bus.tx_data), (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 0);
        check("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
        if (chk) check("rdata_literal", bus.rdata, lit);
        @(posedge clk);
        if (rst_n) model_step(fn, a, wd, rdy);
        #1;
    endtask

    task automatic ld(input int fn, input logic [31:0] a, input logic [31:0] lit);
        cyc(fn, a, 0, 1, lit);
    endtask

    task automatic st(input int fn, input logic [31:0] a, input logic [31:0] wd);
        cyc(fn, a, wd, 0, 0);
    endtask

    initial begin
        bus.mem_fn = 3'(LW); bus.addr = ST; bus.wdata = 0; bus.tx_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tx_valid", 32'(bus.tx_valid), 0);
        check("reset_tx_data", 32'(bus.tx_data), 0);
        check("reset_misalign", 32'(bus.misalign_err), 0);
        rst_n = 1'b1;
        ld(LW, ST, 32'h2);

        // RAM lanes
        st(SW, 32'h10, 32'h8765_4321);
        st(SB, 32'h11, 32'hAA);
        ld(LB, 32'h11, 32'hFFFF_FFAA);
        ld(LBU, 32'h11, 32'h0000_00AA);
        ld(LH, 32'h10, 32'hFFFF_AA21);
        ld(LHU, 32'h12, 32'h0000_8765);
        ld(LW, 32'h10, 32'h8765_AA21);

        // Misalignment
        st(SW, 32'h20, 32'h1122_3344);
        ld(LW, 32'h13, 32'h0);
        check("misalign_sticky", 32'(bus.misalign_err), 1);
        st(SH, 32'h21, 32'h9999);
        ld(LW, 32'h20, 32'h1122_3344);

        // FIFO fill past full, then drain
        rdy = 0;
        for (int i = 1; i <= 9; i++) st(SB, TX, 32'(i));
        ld(LW, ST, 32'h0C);
        ld(LW, TX, 32'h1);
        rdy = 1;
        for (int i = 1; i <= 8; i++) ld(LW, TX, 32'(i));
        ld(LW, ST, 32'h0A);

        // Reset mid-drain, with a store in flight that must be lost
        rdy = 0;
        for (int i = 0; i < 5; i++) st(SB, TX, 32'h40 + 32'(i));
        rdy = 1;
        ld(LW, TX, 32'h40);
        ld(LW, TX, 32'h41);
        bus.mem_fn = 3'(SW); bus.addr = 32'h10; bus.wdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_tx_valid", 32'(bus.tx_valid), 0);
        check("rst_async_misalign", 32'(bus.misalign_err), 0);
        m_fifo.delete(); m_ovf = 0; m_mis = 0; m_cyc = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        ld(LW, ST, 32'h2);
        ld(LW, 32'h10, 32'h8765_AA21);
        ld(LW, 32'h20, 32'h1122_3344);

        // Push and pop together while full
        rdy = 0;
        for (int i = 0; i < 8; i++) st(SB, TX, 32'h10 + 32'(i));
        ld(LW, ST, 32'h4);
        rdy = 1;
        st(SB, TX, 32'h55);
        rdy = 0;
        ld(LW, ST, 32'h4);
        rdy = 1;
        for (int i = 1; i <= 7; i++) ld(LW, TX, 32'h10 + 32'(i));
        ld(LW, TX, 32'h55);
        ld(LW, ST, 32'h2);

        // CYCLE load and wrap
        rdy = 0;
        st(SW, CY, 32'hFFFF_FFFE);
        cyc(LW, CY, 0, 0, 0);
        ld(LW, CY, 32'hFFFF_FFFF);
        ld(LW, CY, 32'h0000_0000);
        st(SB, CY, 32'h0);
        ld(LW, CY, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
